// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acq_pkg
// Description : Shared state encoding and constants for the acquisition
//               run sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package acq_pkg;

  // Debug-visible state codes; the numeric values appear on the state port.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CLK  = 3'd1,
    WAIT_TICK = 3'd2,
    FRAME     = 3'd3,
    FINISH    = 3'd4
  } acq_state_t;

  // Maximum number of cycles a frame may stay in flight.
  localparam int c_timeout_default = 4096;

  // Width of the optional dropped-tick counter.
  localparam int c_ovr_cnt_w = 16;

endpackage
`default_nettype wire

// File: rtl/acq_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : acq_tick_gen
// Description : Sample-period counter. Raises tick when the count reaches
//               zero, then reloads period-1 (a period of 0 behaves as 1).
// Revision    : 1.0 - initial release
// ============================================================================
module acq_tick_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                load_zero,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

  logic [PERIOD_W-1:0] r_count;
  logic [PERIOD_W-1:0] w_reload;

  assign w_reload = (period == '0) ? '0 : (period - c_one);
  assign tick     = enable && (r_count == '0);

  // Count down while enabled; load_zero makes the next cycle a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load_zero) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == '0) ? w_reload : (r_count - c_one);
    end
  end

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acq_sequencer
// Description : Run-level controller for the SPI acquisition engine. Waits
//               for a stable clock, issues one frame start per sample period,
//               counts completed frames and flags overruns and hung frames.
//               Optional macro ACQ_OVERRUN_COUNT_EN adds a saturating
//               dropped-tick counter on port overrun_count.
// Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int TS_W     = 32,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = c_timeout_default
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk_stable,
  input  logic                cfg_continuous,
  input  logic [TS_W-1:0]     cfg_max_timestep,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                spi_busy,
  input  logic                spi_frame_done,
  output logic                spi_start,
  output logic [TS_W-1:0]     timestamp,
  output logic                running,
  output logic                done,
  output logic                overrun,
  output logic                timeout_err,
  output logic [2:0]          state
`ifdef ACQ_OVERRUN_COUNT_EN
  ,
  output logic [c_ovr_cnt_w-1:0] overrun_count
`endif
);

  localparam int                c_to_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
  localparam logic [TS_W-1:0]   c_ts_one  = TS_W'(1);

  acq_state_t          r_state, w_next;
  logic                r_cont;
  logic [TS_W-1:0]     r_max;
  logic [PERIOD_W-1:0] r_period;
  logic [TS_W-1:0]     r_ts;
  logic [TS_W-1:0]     w_ts_plus;
  logic                r_stop_pend;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_spi_start, r_running, r_done, r_overrun, r_timeout;
  logic                w_tick, w_tick_en, w_load_zero;
  logic                w_start_acc, w_drop, w_frame_end, w_to_hit;

  assign w_ts_plus   = r_ts + c_ts_one;
  assign w_tick_en   = (r_state == WAIT_TICK) || (r_state == FRAME);
  assign w_load_zero = (r_state == WAIT_CLK) && (w_next == WAIT_TICK);

  acq_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (w_tick_en),
    .load_zero (w_load_zero),
    .period    (r_period),
    .tick      (w_tick)
  );

  // Next-state decode plus the per-cycle events that update counters/flags.
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_drop      = 1'b0;
    w_frame_end = 1'b0;
    w_to_hit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_start) begin
          w_start_acc = 1'b1;
          w_next      = WAIT_CLK;
        end
      end
      WAIT_CLK: begin
        // An empty burst ends without waiting for the clock.
        if (!r_cont && (r_max == '0)) w_next = FINISH;
        else if (cmd_stop)            w_next = FINISH;
        else if (clk_stable)          w_next = WAIT_TICK;
      end
      WAIT_TICK: begin
        w_drop = w_tick && spi_busy;
        if (cmd_stop)                   w_next = FINISH;
        else if (!clk_stable)           w_next = WAIT_CLK;
        else if (w_tick && !spi_busy)   w_next = FRAME;
      end
      FRAME: begin
        // Ticks during a frame are dropped, never deferred.
        w_drop = w_tick;
        if (spi_frame_done) begin
          w_frame_end = 1'b1;
          if ((!r_cont && (w_ts_plus == r_max)) || r_stop_pend || cmd_stop)
            w_next = FINISH;
          else
            w_next = WAIT_TICK;
        end else if (r_to_cnt == c_to_last) begin
          w_to_hit = 1'b1;
          w_next   = FINISH;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and registered pulse/level outputs derived from w_next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_spi_start <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_next;
      r_spi_start <= (w_next == FRAME) && (r_state != FRAME);
      r_running   <= (w_next == WAIT_CLK) || (w_next == WAIT_TICK) || (w_next == FRAME);
      r_done      <= (w_next == FINISH);
      r_stop_pend <= ((r_state == FRAME) && (w_next == FRAME)) ? (r_stop_pend | cmd_stop) : 1'b0;
      r_to_cnt    <= ((r_state == FRAME) && (w_next == FRAME)) ? (r_to_cnt + 1'b1) : '0;
    end
  end

  // Run configuration, timestamp and sticky flags; all reset on accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cont    <= 1'b0;
      r_max     <= '0;
      r_period  <= '0;
      r_ts      <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_start_acc) begin
      r_cont    <= cfg_continuous;
      r_max     <= cfg_max_timestep;
      r_period  <= cfg_period;
      r_ts      <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_frame_end) r_ts      <= w_ts_plus;
      if (w_drop)      r_overrun <= 1'b1;
      if (w_to_hit)    r_timeout <= 1'b1;
    end
  end

`ifdef ACQ_OVERRUN_COUNT_EN
  logic [c_ovr_cnt_w-1:0] r_ovr_cnt;

  // Saturating count of every dropped tick in the current run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr_cnt <= '0;
    end else if (w_start_acc) begin
      r_ovr_cnt <= '0;
    end else if (w_drop && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign overrun_count = r_ovr_cnt;
`endif

  assign spi_start   = r_spi_start;
  assign timestamp   = r_ts;
  assign running     = r_running;
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_sequencer
// Description : Self-checking bench for acq_sequencer. Expected frame-start
//               and done cycles are queued when a run is launched and
//               compared as the DUT pulses. Honours ACQ_OVERRUN_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;
  import acq_pkg::*;

  localparam int TS_W     = 32;
  localparam int PERIOD_W = 16;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                clk_stable = 1'b1;
  logic                cfg_continuous = 1'b0;
  logic [TS_W-1:0]     cfg_max_timestep = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                cmd_start = 1'b0;
  logic                cmd_stop = 1'b0;
  logic                spi_busy = 1'b0;
  logic                spi_frame_done = 1'b0;
  logic                spi_start;
  logic [TS_W-1:0]     timestamp;
  logic                running, done, overrun, timeout_err;
  logic [2:0]          state;
`ifdef ACQ_OVERRUN_COUNT_EN
  logic [15:0]         overrun_count;
`endif

  acq_sequencer #(.TS_W(TS_W), .PERIOD_W(PERIOD_W), .TIMEOUT(4096)) dut (
    .clk(clk), .reset_n(reset_n), .clk_stable(clk_stable),
    .cfg_continuous(cfg_continuous), .cfg_max_timestep(cfg_max_timestep),
    .cfg_period(cfg_period), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .spi_busy(spi_busy), .spi_frame_done(spi_frame_done),
    .spi_start(spi_start), .timestamp(timestamp), .running(running),
    .done(done), .overrun(overrun), .timeout_err(timeout_err), .state(state)
`ifdef ACQ_OVERRUN_COUNT_EN
    , .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int q_start[$];
  int q_done[$];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Engine model: busy for eng_len cycles from spi_start, frame_done in the last one.
  int eng_len = 1;
  int eng_end = 0;
  bit eng_active = 1'b0;
  bit eng_hang = 1'b0;
  initial forever begin
    @(negedge clk);
    if (spi_start) begin
      check(!spi_busy, "start_while_busy", spi_busy, 0);
      eng_active = 1'b1;
      eng_end    = cyc + eng_len - 1;
    end
    spi_busy       = eng_active;
    spi_frame_done = eng_active && !eng_hang && (cyc == eng_end);
    if (eng_active && !eng_hang && (cyc == eng_end)) eng_active = 1'b0;
  end

  // Scoreboard: every start/done pulse must match the head of its queue.
  initial forever begin
    int e;
    @(negedge clk);
    if (spi_start) begin
      if (q_start.size() == 0) check(1'b0, "unexpected_spi_start", cyc, -1);
      else begin e = q_start.pop_front(); check(cyc == e, "spi_start_cycle", cyc, e); end
    end
    if (done) begin
      if (q_done.size() == 0) check(1'b0, "unexpected_done", cyc, -1);
      else begin e = q_done.pop_front(); check(cyc == e, "done_cycle", cyc, e); end
    end
  end

  // Tick-level model of a run with clk_stable held high: ticks at n+2+k*P,
  // a tick starts a frame the next cycle unless a frame is still in flight.
  task automatic plan(input int n, input bit cont, input int max, input int per,
                      input int b, input int stop);
    int p, t, free, ts, sa, e;
    p  = (per == 0) ? 1 : per;
    sa = (stop >= 0) ? n + stop : -1;
    if (!cont && max == 0) begin q_done.push_back(n + 2); return; end
    t = n + 2; free = n + 1; ts = 0;
    for (int i = 0; i < 1000; i++) begin
      if (t < free) begin t += p; continue; end
      if (sa >= free && sa <= t) begin q_done.push_back(sa + 1); return; end
      q_start.push_back(t + 1);
      e = t + b;
      ts++;
      if ((!cont && ts == max) || (sa >= t + 1 && sa <= e)) begin
        q_done.push_back(e + 1);
        return;
      end
      free = e + 1;
      t += p;
    end
  endtask

  typedef struct {
    bit cont; int max; int period; int busy; int stop;
    int exp_ts; int exp_drops;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit ok;
    eng_len = v.busy;
    @(negedge clk);
    cfg_continuous   = v.cont;
    cfg_max_timestep = TS_W'(v.max);
    cfg_period       = PERIOD_W'(v.period);
    cmd_start        = 1'b1;
    cmd_stop         = (v.stop == 0);
    n = cyc;
    plan(n, v.cont, v.max, v.period, v.busy, v.stop);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Configuration must be latched at the accepted start.
        cmd_start        = 1'b0;
        cfg_continuous   = ~v.cont;
        cfg_max_timestep = TS_W'($urandom);
        cfg_period       = PERIOD_W'($urandom);
      end
      cmd_stop = (v.stop > 0) && (cyc == n + v.stop);
      if (q_done.size() == 0 && q_start.size() == 0) begin ok = 1'b1; break; end
    end
    cmd_stop = 1'b0;
    check(ok, $sformatf("vec%0d_drain", idx), ok, 1);
    @(negedge clk);
    check(state == 3'(IDLE), $sformatf("vec%0d_state", idx), state, 0);
    check(!running, $sformatf("vec%0d_running", idx), running, 0);
    check(timestamp == TS_W'(v.exp_ts), $sformatf("vec%0d_ts", idx), timestamp, v.exp_ts);
    check(overrun == (v.exp_drops != 0), $sformatf("vec%0d_overrun", idx), overrun, v.exp_drops != 0);
    check(!timeout_err, $sformatf("vec%0d_timeout", idx), timeout_err, 0);
`ifdef ACQ_OVERRUN_COUNT_EN
    check(overrun_count == 16'(v.exp_drops), $sformatf("vec%0d_ovr_cnt", idx), overrun_count, v.exp_drops);
`endif
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      if (q_done.size() == 0 && q_start.size() == 0) break;
      @(negedge clk);
    end
    check(k < budget, name, k, budget);
    @(negedge clk);
  endtask

  task automatic start_run(input bit cont, input int max, input int per, output int n);
    @(negedge clk);
    cfg_continuous   = cont;
    cfg_max_timestep = TS_W'(max);
    cfg_period       = PERIOD_W'(per);
    cmd_start        = 1'b1;
    n = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(!spi_start, {tag, "_spi_start"}, spi_start, 0);
    check(timestamp == '0, {tag, "_ts"}, timestamp, 0);
    check(!running, {tag, "_running"}, running, 0);
    check(!done, {tag, "_done"}, done, 0);
    check(!overrun, {tag, "_overrun"}, overrun, 0);
    check(!timeout_err, {tag, "_timeout"}, timeout_err, 0);
    check(state == 3'(IDLE), {tag, "_state"}, state, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int n, m;
    //            cont max per busy stop  ts drops
    vecs[0] = '{1'b0, 3, 100, 80,  -1,   3, 0};
    vecs[1] = '{1'b0, 2,   0,  3,  -1,   2, 6};
    vecs[2] = '{1'b0, 4,  10,  5,  -1,   4, 0};
    vecs[3] = '{1'b1, 0, 100, 80, 113,   2, 0};
    vecs[4] = '{1'b1, 0,  50, 20,  40,   1, 0};
    vecs[5] = '{1'b1, 0,  50, 80, 250,   3, 3};
    vecs[6] = '{1'b0, 0,  10,  5,  -1,   0, 0};
    vecs[7] = '{1'b0, 1,   1,  1,  -1,   1, 1};
    vecs[8] = '{1'b0, 1,  10,  5,   0,   1, 0};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Clock absent at start: no frame until 2 cycles after clk_stable rises.
    clk_stable = 1'b0;
    eng_len = 5;
    start_run(1'b0, 1, 10, n);
    repeat (200) @(negedge clk);
    check(state == 3'(WAIT_CLK), "clkloss_wait_state", state, 1);
    check(running, "clkloss_running", running, 1);
    clk_stable = 1'b1;
    m = cyc;
    q_start.push_back(m + 2);
    q_done.push_back(m + 7);
    drain(100, "clkloss_drain");
    check(timestamp == 1, "clkloss_ts", timestamp, 1);

    // clk_stable drop in WAIT_TICK returns to WAIT_CLK; tick due on return.
    start_run(1'b1, 0, 100, n);
    q_start.push_back(n + 3);
    while (cyc < n + 20) @(negedge clk);
    clk_stable = 1'b0;
    @(negedge clk);
    check(state == 3'(WAIT_CLK), "clkdrop_state", state, 1);
    while (cyc < n + 30) @(negedge clk);
    clk_stable = 1'b1;
    q_start.push_back(n + 32);
    while (cyc < n + 50) @(negedge clk);
    cmd_stop = 1'b1;
    q_done.push_back(n + 51);
    @(negedge clk);
    cmd_stop = 1'b0;
    drain(100, "clkdrop_drain");
    check(timestamp == 2, "clkdrop_ts", timestamp, 2);

    // Hung frame: done and timeout_err exactly 4096 cycles into FRAME.
    eng_hang = 1'b1;
    eng_len  = 1;
    start_run(1'b0, 1, 10, n);
    q_start.push_back(n + 3);
    q_done.push_back(n + 3 + 4096);
    drain(5000, "timeout_drain");
    check(timeout_err, "timeout_err", timeout_err, 1);
    check(timestamp == 0, "timeout_ts", timestamp, 0);
    check(state == 3'(IDLE), "timeout_state", state, 0);
    eng_hang   = 1'b0;
    eng_active = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of frame 2: outputs clear, no done.
    eng_len = 80;
    start_run(1'b0, 3, 100, n);
    q_start.push_back(n + 3);
    q_start.push_back(n + 103);
    while (cyc < n + 120) @(negedge clk);
    check(timestamp == 1, "prereset_ts", timestamp, 1);
    check(running, "prereset_running", running, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q_start.delete();
    q_done.delete();
    eng_active = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check(state == 3'(IDLE), "after_reset_state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
